// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: 4-way round-robin bus arbiter (IDLE/GRANT/RELEASE).
// Define ARB_TIMEOUT_EN to revoke grants held for TIMEOUT_CYCLES cycles.
`timescale 1ns/1ps
module bus_grant_arbiter #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic       gnt_valid,
   output logic [1:0] gnt_id,
   output logic       gnt_event,
   output logic       timeout_o
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] id_q, id_d, last_q, last_d, win;
   logic       evt_q, evt_d, to_q, to_d, tmo;
   if (TIMEOUT_CYCLES == 8'd0) begin : g_chk
      $error("TIMEOUT_CYCLES must be 1..255");
   end
`ifdef ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   assign tmo = cnt_q == TIMEOUT_CYCLES - 8'd1;
   assign cnt_d = (state_q == GRANT) ? cnt_q + 8'd1 : 8'd0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 8'd0;
      else cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif
   // Lowest rotation distance from last owner wins; k=4 wraps back to last owner.
   always_comb begin
      win = last_q;
      for (int k = 4; k >= 1; k--)
         if (req[last_q + 2'(k)]) win = last_q + 2'(k);
   end
   always_comb begin
      state_d = state_q;
      gnt_d = gnt_q;
      id_d = id_q;
      last_d = last_q;
      evt_d = 1'b0;
      to_d = 1'b0;
      if (state_q == IDLE && req != 4'd0) begin
         state_d = GRANT;
         gnt_d = 4'b0001 << win;
         id_d = win;
         evt_d = 1'b1;
      end else if (state_q == GRANT && (done || !req[id_q] || tmo)) begin
         state_d = RELEASE;
         gnt_d = 4'd0;
         last_d = id_q;
         to_d = tmo & ~done;
      end else if (state_q == RELEASE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q <= 4'd0;
         id_q <= 2'd0;
         last_q <= 2'd3;
         evt_q <= 1'b0;
         to_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q <= gnt_d;
         id_q <= id_d;
         last_q <= last_d;
         evt_q <= evt_d;
         to_q <= to_d;
      end
   end
   assign gnt = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id = id_q;
   assign gnt_event = evt_q;
   assign timeout_o = to_q;
endmodule

// File: tb/tb_bus_grant_arbiter.sv
// tb_bus_grant_arbiter: directed table, corner sequences and random traffic vs a reference model.
`timescale 1ns/1ps
module tb_bus_grant_arbiter;
   localparam int TO = 4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'd0;
   logic       done = 1'b0;
   logic [3:0] gnt;
   logic       gnt_valid, gnt_event, timeout_o;
   logic [1:0] gnt_id;
   int n_cmp = 0;
   int n_bad = 0;
   bus_grant_arbiter #(.TIMEOUT_CYCLES(8'(TO))) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt),
      .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_event(gnt_event), .timeout_o(timeout_o)
   );
   always #5 clk = ~clk;
   // Reference model: phase 0 = free, 1 = owned, 2 = turnaround.
   int phase, owner, last, age;
   logic [3:0] e_gnt;
   logic e_evt, e_to, prev_evt;
   task automatic model_reset();
      phase = 0;
      owner = 0;
      last = 3;
      age = 0;
      e_gnt = 4'd0;
      e_evt = 1'b0;
      e_to = 1'b0;
      prev_evt = 1'b0;
   endtask
   task automatic model_step(input logic [3:0] r, input logic d);
      bit expire;
      e_evt = 1'b0;
      e_to = 1'b0;
`ifdef ARB_TIMEOUT_EN
      expire = (age == TO - 1);
`else
      expire = 1'b0;
`endif
      if (phase == 2) phase = 0;
      else if (phase == 1) begin
         if (d || !r[owner] || expire) begin
            phase = 2;
            last = owner;
            e_to = expire && !d;
         end else age++;
      end else if (r != 4'd0) begin
         for (int k = 4; k >= 1; k--)
            if (r[(last + k) % 4]) owner = (last + k) % 4;
         phase = 1;
         age = 0;
         e_evt = 1'b1;
      end
      e_gnt = (phase == 1) ? 4'(1 << owner) : 4'd0;
   endtask
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic step_chk();
      model_step(req, done);
      @(posedge clk);
      #1;
      check("gnt", gnt, e_gnt);
      check("gnt_valid", gnt_valid, |e_gnt);
      check("gnt_id", gnt_id, owner);
      check("gnt_event", gnt_event, e_evt);
      check("timeout_o", timeout_o, e_to);
      check("event_gap", prev_evt & gnt_event, 0);
      prev_evt = gnt_event;
   endtask
   typedef struct packed {
      logic [3:0] r;
      logic       d;
      logic [3:0] g;
      logic [1:0] id;
      logic       ev;
   } vec_t;
   vec_t tbl[30];
   logic [3:0] tg[7];
   logic       tt[7];
   initial begin
      tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
      tbl[2]  = '{4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
      tbl[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0};
      tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 2'd1, 1'b0};
      tbl[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
      tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0};
      tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 2'd2, 1'b0};
      tbl[9]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
      tbl[10] = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0};
      tbl[11] = '{4'b1111, 1'b0, 4'b0000, 2'd3, 1'b0};
      tbl[12] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
      tbl[13] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
      tbl[14] = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0};
      tbl[15] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
      tbl[16] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0};
      tbl[17] = '{4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0};
      tbl[18] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
      tbl[19] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0};
      tbl[20] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
      tbl[21] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
      tbl[22] = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0};
      tbl[23] = '{4'b0001, 1'b0, 4'b0000, 2'd1, 1'b0};
      tbl[24] = '{4'b0001, 1'b0, 4'b0000, 2'd1, 1'b0};
      tbl[25] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
      tbl[26] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
      tbl[27] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
      tbl[28] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
      tbl[29] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
      tg = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
      tt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      model_reset();
      #2;
      check("rst_gnt", gnt, 0);
      check("rst_valid", gnt_valid, 0);
      check("rst_id", gnt_id, 0);
      check("rst_event", gnt_event, 0);
      check("rst_timeout", timeout_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         req = tbl[i].r;
         done = tbl[i].d;
         model_step(req, done);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].g);
         check($sformatf("tbl%0d_valid", i), gnt_valid, |tbl[i].g);
         check($sformatf("tbl%0d_id", i), gnt_id, tbl[i].id);
         check($sformatf("tbl%0d_event", i), gnt_event, tbl[i].ev);
         check($sformatf("tbl%0d_timeout", i), timeout_o, 0);
      end
      prev_evt = gnt_event;
      req = 4'b0100;
      done = 1'b0;
      step_chk();
      check("pre_rst_gnt", gnt, 4'b0100);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_gnt", gnt, 0);
      check("async_rst_valid", gnt_valid, 0);
      check("async_rst_id", gnt_id, 0);
      model_reset();
      req = 4'b0101;
      #2;
      rst_n = 1'b1;
      step_chk();
      check("post_rst_gnt", gnt, 4'b0001);
      req = 4'b0000;
      repeat (3) step_chk();
`ifdef ARB_TIMEOUT_EN
      req = 4'b1000;
      for (int i = 0; i < 7; i++) begin
         step_chk();
         check($sformatf("tmo%0d_gnt", i), gnt, tg[i]);
         check($sformatf("tmo%0d_pulse", i), timeout_o, tt[i]);
      end
`endif
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 4) == 0);
         step_chk();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bus_grant_arbiter.md
BUS_GRANT_ARBITER -- requirements
Module: bus_grant_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd200: maximum cycles a grant may be held (8-bit, legal 1..255).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 4: requests; bit0 mem, bit1 sha, bit2 aes, bit3 ctrl; level-sensitive.
REQ-005 SHALL have port done, input, 1: end-of-transaction pulse from the current owner.
REQ-006 SHALL have port gnt, output, 4: one-hot grant, same bit order as req; registered.
REQ-007 SHALL have port gnt_valid, output, 1: high while any gnt bit is high.
REQ-008 SHALL have port gnt_id, output, 2: binary index of the current owner; holds the last owner when gnt_valid=0.
REQ-009 SHALL have port gnt_event, output, 1: one-cycle pulse in the first cycle of each new grant.
REQ-010 SHALL have port timeout_o, output, 1: one-cycle pulse when a grant is forcibly revoked.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT and RELEASE.
REQ-012 IDLE: if req!=0, SHALL select a winner and enter GRANT next cycle; gnt, gnt_valid and gnt_event SHALL assert on that edge (1-cycle request-to-grant latency).
REQ-013 IDLE with req=0: SHALL remain in IDLE with gnt=0.
REQ-014 Selection SHALL be round-robin: search starts at (last_id+1) mod 4 and wraps, so the first set req bit wins.
REQ-015 GRANT: gnt SHALL stay stable and one-hot; req changes of other requesters SHALL be ignored.
REQ-016 GRANT to RELEASE SHALL occur on done=1, or when the owner's req bit is 0 (abandon).
REQ-017 On leaving GRANT, last_id SHALL be set to the owner, and gnt and gnt_valid SHALL drop to 0 on that edge.
REQ-018 RELEASE SHALL last exactly one cycle with gnt=0 (bus turnaround), then go to IDLE; a new grant therefore appears at the earliest 2 cycles after done.
REQ-019 done while in IDLE or RELEASE SHALL be ignored.
REQ-020 done=1 together with the owner's req still high SHALL still release; that owner becomes lowest priority.
REQ-021 A single persistent requester SHALL be re-granted every 3 cycles (GRANT, RELEASE, IDLE).
REQ-022 gnt_event SHALL never be high in two consecutive cycles.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force: state IDLE, gnt=0, gnt_valid=0, gnt_id=0, gnt_event=0, timeout_o=0, last_id=3 (mem highest priority first), timeout counter=0.
REQ-024 Reset asserted mid-GRANT SHALL drop the grant without passing through RELEASE; the first arbitration after deassertion SHALL follow REQ-012 and REQ-014 with last_id=3.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on grant and increment each GRANT cycle; at count==TIMEOUT_CYCLES-1 with no done, the block SHALL move to RELEASE, pulse timeout_o for 1 cycle and update last_id per REQ-017.
REQ-026 done and timeout in the same cycle SHALL be treated as done (timeout_o stays 0).
REQ-027 Macro ARB_TIMEOUT_EN undefined: no counter SHALL exist, timeout_o SHALL be tied 0, TIMEOUT_CYCLES SHALL be unused, and a grant SHALL be held indefinitely until done or abandon.

Verification
REQ-028 Reset, then req=4'b1111 -> gnt=4'b0001, gnt_id=0, gnt_event=1 one cycle later; successive done pulses -> grants 0010, 0100, 1000, 0001.
REQ-029 req=4'b0100 held, done every GRANT cycle -> gnt=0100 in a 3-cycle pattern; gnt=0 in the cycle after each done.
REQ-030 Owner sha (gnt=0010) drops req[1] without done -> RELEASE next cycle, then mem wins if req[0]=1.
REQ-031 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, req=4'b1000, done=0 -> gnt=1000 for exactly 4 cycles, timeout_o pulses 1 cycle, re-grant 2 cycles later.
REQ-032 rst_n pulled low mid-GRANT (gnt=0100) -> gnt=0 without waiting for a clock edge; after release with req=4'b0101 -> gnt=0001.
REQ-033 done pulsed in IDLE with req=0 -> no state change, all outputs remain 0.
